output_credit_controller: RTL and testbench

Per-output-port, per-downstream-VC credit tracker that produces the `on_off` flow-control vector consumed by `switch_allocator`. It counts free buffer slots in each downstream router's input VCs:
- decrements when the switch allocator forwards a flit on an output port;
- increments when the downstream router returns a credit.

It sits between the allocator's `valid_flit_o`/`vc_sel` outputs and the credit-return wires from neighbouring routers. It gates switch requests so that a flit is never sent to a full downstream VC.

---
 rtl/output_credit_if.sv | 28 ++
 rtl/output_credit_controller.sv | 95 +++++++++
 tb/tb_output_credit_controller.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/output_credit_if.sv
// Flow-control bundle between a router output stage and its credit controller:
// allocator send events and downstream credit returns in, on/off and status out.
interface output_credit_if #(
    parameter int PORT_NUM    = 5,
    parameter int VC_NUM      = 2,
    parameter int BUFFER_SIZE = 8
);
    localparam int VC_SIZE = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
    localparam int CRED_W  = $clog2(BUFFER_SIZE + 1);

    logic [PORT_NUM-1:0]                           flit_sent_i;
    logic [PORT_NUM-1:0][VC_SIZE-1:0]              flit_vc_i;
    logic [PORT_NUM-1:0]                           credit_valid_i;
    logic [PORT_NUM-1:0][VC_SIZE-1:0]              credit_vc_i;
    logic [PORT_NUM-1:0][VC_NUM-1:0]               on_off_o;
    logic [PORT_NUM-1:0][VC_NUM-1:0][CRED_W-1:0]   credit_count_o;
    logic [PORT_NUM-1:0]                           error_o;

    modport master (
        output flit_sent_i, flit_vc_i, credit_valid_i, credit_vc_i,
        input  on_off_o, credit_count_o, error_o
    );

    modport slave (
        input  flit_sent_i, flit_vc_i, credit_valid_i, credit_vc_i,
        output on_off_o, credit_count_o, error_o
    );
endinterface

// File: rtl/output_credit_controller.sv
// Per-port, per-downstream-VC credit counters producing the allocator on/off vector,
// with a sticky per-port protocol-violation flag.
module output_credit_controller #(
    parameter int PORT_NUM    = 5,
    parameter int VC_NUM      = 2,
    parameter int BUFFER_SIZE = 8
) (
    input  logic             clk,
    input  logic             rst,
    output_credit_if.slave   bus
);
    localparam int VC_SIZE = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
    localparam int CRED_W  = $clog2(BUFFER_SIZE + 1);
    localparam logic [CRED_W-1:0] FULL = CRED_W'(BUFFER_SIZE);

    logic [PORT_NUM-1:0][VC_NUM-1:0][CRED_W-1:0] r_cnt;
    logic [PORT_NUM-1:0][VC_NUM-1:0][CRED_W-1:0] w_cnt_nxt;
    logic [PORT_NUM-1:0][VC_NUM-1:0]             w_dec;
    logic [PORT_NUM-1:0][VC_NUM-1:0]             w_inc;
    logic [PORT_NUM-1:0][VC_NUM-1:0]             w_on_off;
    logic [PORT_NUM-1:0]                         r_err;
    logic [PORT_NUM-1:0]                         w_err_set;
    logic [PORT_NUM-1:0]                         w_bad_vc;

    // Only a non-power-of-two VC count leaves unused VC encodings to flag.
    generate
        if (VC_NUM < (1 << VC_SIZE)) begin : g_vc_chk
            always_comb begin
                w_bad_vc = '0;
                for (int p = 0; p < PORT_NUM; p++) begin
                    w_bad_vc[p] = (bus.flit_sent_i[p]    && (bus.flit_vc_i[p]   >= VC_SIZE'(VC_NUM))) ||
                                  (bus.credit_valid_i[p] && (bus.credit_vc_i[p] >= VC_SIZE'(VC_NUM)));
                end
            end
        end else begin : g_vc_full
            assign w_bad_vc = '0;
        end
    endgenerate

    always_comb begin
        w_dec = '0;
        w_inc = '0;
        for (int p = 0; p < PORT_NUM; p++) begin
            for (int v = 0; v < VC_NUM; v++) begin
                w_dec[p][v] = bus.flit_sent_i[p]    && (bus.flit_vc_i[p]   == VC_SIZE'(v));
                w_inc[p][v] = bus.credit_valid_i[p] && (bus.credit_vc_i[p] == VC_SIZE'(v));
            end
        end
    end

    // A send and a credit on the same VC in one cycle cancel, even at the limits.
    always_comb begin
        w_cnt_nxt = r_cnt;
        w_err_set = w_bad_vc;
        for (int p = 0; p < PORT_NUM; p++) begin
            for (int v = 0; v < VC_NUM; v++) begin
                if (w_dec[p][v] && !w_inc[p][v]) begin
                    if (r_cnt[p][v] == '0) w_err_set[p] = 1'b1;
                    else                   w_cnt_nxt[p][v] = r_cnt[p][v] - CRED_W'(1);
                end else if (w_inc[p][v] && !w_dec[p][v]) begin
                    if (r_cnt[p][v] == FULL) w_err_set[p] = 1'b1;
                    else                     w_cnt_nxt[p][v] = r_cnt[p][v] + CRED_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < PORT_NUM; p++) begin
                for (int v = 0; v < VC_NUM; v++) begin
                    r_cnt[p][v] <= FULL;
                end
            end
            r_err <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_err <= r_err | w_err_set;
        end
    end

    // On/off comes from registered state only, keeping the allocator loop acyclic.
    always_comb begin
        w_on_off = '0;
        for (int p = 0; p < PORT_NUM; p++) begin
            for (int v = 0; v < VC_NUM; v++) begin
                w_on_off[p][v] = (r_cnt[p][v] != '0);
            end
        end
    end

    assign bus.on_off_o       = w_on_off;
    assign bus.credit_count_o = r_cnt;
    assign bus.error_o        = r_err;
endmodule

// File: tb/tb_output_credit_controller.sv
// Scoreboard bench for output_credit_controller: directed corner cases plus
// random traffic against a delayed-credit downstream model.
module tb_output_credit_controller;
    localparam int P  = 5;
    localparam int V  = 2;
    localparam int B  = 8;
    localparam int CW = 4;

    typedef struct {
        logic [P*V*CW-1:0] cnt;
        logic [P*V-1:0]    onoff;
        logic [P-1:0]      err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    output_credit_if #(.PORT_NUM(P), .VC_NUM(V), .BUFFER_SIZE(B)) bus ();

    output_credit_controller #(.PORT_NUM(P), .VC_NUM(V), .BUFFER_SIZE(B)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   n_chk  = 0;
    int   n_pass = 0;
    int   mdl_cnt [P][V];
    logic [P-1:0] mdl_err;
    exp_t sb [$];
    int   pend_due [P][$];
    int   pend_vc  [P][$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic mdl_reset();
        for (int p = 0; p < P; p++)
            for (int v = 0; v < V; v++) mdl_cnt[p][v] = B;
        mdl_err = '0;
    endtask

    function automatic exp_t mdl_pack();
        exp_t e;
        for (int p = 0; p < P; p++) begin
            for (int v = 0; v < V; v++) begin
                e.cnt[(p*V+v)*CW +: CW] = CW'(mdl_cnt[p][v]);
                e.onoff[p*V+v]          = (mdl_cnt[p][v] > 0);
            end
        end
        e.err = mdl_err;
        return e;
    endfunction

    task automatic mdl_update();
        for (int p = 0; p < P; p++) begin
            for (int v = 0; v < V; v++) begin
                bit d, i;
                d = bus.flit_sent_i[p]    && (int'(bus.flit_vc_i[p])   == v);
                i = bus.credit_valid_i[p] && (int'(bus.credit_vc_i[p]) == v);
                if (d && !i) begin
                    if (mdl_cnt[p][v] == 0) mdl_err[p] = 1'b1;
                    else mdl_cnt[p][v]--;
                end else if (i && !d) begin
                    if (mdl_cnt[p][v] == B) mdl_err[p] = 1'b1;
                    else mdl_cnt[p][v]++;
                end
            end
        end
    endtask

    task automatic clr();
        bus.flit_sent_i    = '0;
        bus.flit_vc_i      = '0;
        bus.credit_valid_i = '0;
        bus.credit_vc_i    = '0;
    endtask

    task automatic compare_now(input string tag, input exp_t e);
        chk({tag, ".cnt"},   128'(bus.credit_count_o), 128'(e.cnt));
        chk({tag, ".onoff"}, 128'(bus.on_off_o),       128'(e.onoff));
        chk({tag, ".err"},   128'(bus.error_o),        128'(e.err));
    endtask

    // One clock: model consumes current inputs, expectation queued, DUT sampled after edge.
    task automatic step(input string tag);
        exp_t e;
        mdl_update();
        sb.push_back(mdl_pack());
        @(posedge clk);
        #1;
        e = sb.pop_front();
        compare_now(tag, e);
        clr();
    endtask

    task automatic send(input int p, input int v);
        bus.flit_sent_i[p] = 1'b1;
        bus.flit_vc_i[p]   = 1'(v);
    endtask

    task automatic credit(input int p, input int v);
        bus.credit_valid_i[p] = 1'b1;
        bus.credit_vc_i[p]    = 1'(v);
    endtask

    initial begin
        clr();
        mdl_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_now("reset", mdl_pack());
        rst = 1'b0;

        // Drain port 2 VC 1 to empty.
        for (int k = 0; k < 8; k++) begin
            send(2, 1);
            step("p2v1_drain");
        end
        chk("p2v1_off", 128'(bus.on_off_o[2][1]), 128'(0));
        chk("p2v0_on",  128'(bus.on_off_o[2][0]), 128'(1));

        credit(2, 1);
        step("p2v1_credit");
        chk("p2v1_reopen", 128'(bus.on_off_o[2][1]), 128'(1));
        send(2, 1);
        step("p2v1_resend");

        // Simultaneous send + credit at both count limits on port 0 VC 0.
        for (int k = 0; k < 8; k++) begin
            send(0, 0);
            step("p0v0_drain");
        end
        send(0, 0); credit(0, 0);
        step("p0v0_both_at0");
        for (int k = 0; k < 8; k++) begin
            credit(0, 0);
            step("p0v0_fill");
        end
        send(0, 0); credit(0, 0);
        step("p0v0_both_at8");

        // Underflow on port 4, overflow on port 1, both sticky.
        for (int k = 0; k < 9; k++) begin
            send(4, 0);
            step("p4_underflow");
        end
        step("p4_sticky");
        step("p4_sticky");
        credit(1, 1);
        step("p1_overflow");
        chk("err_ports", 128'(bus.error_o), 128'(5'b10010));

        // Async reset mid-traffic with port 3 VC 0 at 3.
        for (int k = 0; k < 5; k++) begin
            send(3, 0);
            step("p3_pre_rst");
        end
        chk("p3_at3", 128'(bus.credit_count_o[3][0]), 128'(3));
        rst = 1'b1;
        #1;
        mdl_reset();
        compare_now("async_rst", mdl_pack());
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Random traffic with a delayed-credit downstream.
        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int p = 0; p < P; p++) begin
                if (pend_due[p].size() > 0 && pend_due[p][0] <= cyc) begin
                    void'(pend_due[p].pop_front());
                    credit(p, pend_vc[p].pop_front());
                end
                if ($urandom_range(0, 9) < 7) begin
                    int v;
                    v = int'($urandom_range(0, V-1));
                    if (mdl_cnt[p][v] == 0) v = 1 - v;
                    if (mdl_cnt[p][v] > 0) begin
                        chk("rnd_nosend0", 128'(bus.on_off_o[p][v]), 128'(1));
                        send(p, v);
                        pend_due[p].push_back(cyc + int'($urandom_range(1, 4)));
                        pend_vc[p].push_back(v);
                    end
                end
            end
            step("rnd");
        end
        chk("rnd_err", 128'(bus.error_o), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
